// File: rtl/kf8259_interrupt_sequencer.sv
// KF8259 interrupt sequencer: priority resolution, in-service tracking,
// the two-pulse 8086 INTA cycle and EOI / rotation handling.
module kf8259_interrupt_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       interrupt_acknowledge,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi_config,
    input  logic       non_specific_eoi,
    input  logic       specific_eoi,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    output logic       interrupt,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [7:0] vector_data,
    output logic       vector_enable
);

    localparam int unsigned LVL_W = 3;
    localparam int unsigned IRQ_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   lp_q, lp_d;
    logic [LVL_W-1:0]   sel_q, sel_d;
    logic               spur_q, spur_d;
    logic [IRQ_W-1:0]   isr_q, isr_d;
    logic [IRQ_W-1:0]   clr_q, clr_d;
    logic [IRQ_W-1:0]   vdata_q, vdata_d;
    logic               venable_q, venable_d;
    logic               freeze_q, freeze_d;
    logic               int_q, int_d;
    logic               ack_prev_q;

    logic               ack_rise;
    logic               ack_fall;
    logic [IRQ_W-1:0]   set_mask;
    logic [IRQ_W-1:0]   auto_clr;
    logic [IRQ_W-1:0]   eoi_clr;
    logic [LVL_W:0]     cand_res;
    logic [LVL_W:0]     top_res;
    logic               cand_valid;
    logic [LVL_W-1:0]   cand;
    logic [LVL_W-1:0]   isr_top;

    // Highest-priority set bit, scanning downward so the last hit is the winner.
    function automatic logic [LVL_W:0] find_top(input logic [IRQ_W-1:0] bits,
                                                input logic [LVL_W-1:0] lowest);
        logic [LVL_W:0]   res;
        logic [LVL_W-1:0] lvl;
        res = '0;
        for (int k = IRQ_W; k >= 1; k--) begin
            lvl = lowest + LVL_W'(k);
            if (bits[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    assign ack_rise   = interrupt_acknowledge & ~ack_prev_q;
    assign ack_fall   = ~interrupt_acknowledge & ack_prev_q;
    assign cand_res   = find_top(interrupt_request_register & ~interrupt_mask, lp_q);
    assign top_res    = find_top(isr_q, lp_q);
    assign cand_valid = cand_res[LVL_W];
    assign cand       = cand_res[LVL_W-1:0];
    assign isr_top    = top_res[LVL_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            lp_q       <= 3'd7;
            sel_q      <= '0;
            spur_q     <= 1'b0;
            isr_q      <= '0;
            clr_q      <= '0;
            vdata_q    <= '0;
            venable_q  <= 1'b0;
            freeze_q   <= 1'b0;
            int_q      <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lp_q       <= lp_d;
            sel_q      <= sel_d;
            spur_q     <= spur_d;
            isr_q      <= isr_d;
            clr_q      <= clr_d;
            vdata_q    <= vdata_d;
            venable_q  <= venable_d;
            freeze_q   <= freeze_d;
            int_q      <= int_d;
            ack_prev_q <= interrupt_acknowledge;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        spur_d   = spur_q;
        lp_d     = lp_q;
        set_mask = '0;
        auto_clr = '0;
        eoi_clr  = '0;

        case (state_q)
            IDLE: begin
                if (ack_rise) begin
                    state_d = ACK1;
                    if (cand_valid) begin
                        sel_d    = cand;
                        spur_d   = 1'b0;
                        set_mask = IRQ_W'(1) << cand;
                    end else begin
                        sel_d  = SPURIOUS_LEVEL;
                        spur_d = 1'b1;
                    end
                end
            end
            ACK1:  if (ack_fall) state_d = WAIT2;
            WAIT2: if (ack_rise) state_d = ACK2;
            ACK2: begin
                if (ack_fall) begin
                    state_d = IDLE;
                    if (auto_eoi_config && !spur_q) auto_clr = IRQ_W'(1) << sel_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Specific EOI takes precedence over non-specific in the same cycle.
        if (specific_eoi) begin
            eoi_clr = IRQ_W'(1) << eoi_level;
            if (rotate_on_eoi) lp_d = eoi_level;
        end else if (non_specific_eoi && (isr_q != '0)) begin
            eoi_clr = IRQ_W'(1) << isr_top;
            if (rotate_on_eoi) lp_d = isr_top;
        end

        isr_d     = (isr_q & ~eoi_clr & ~auto_clr) | set_mask;
        clr_d     = set_mask;
        freeze_d  = (state_d != IDLE);
        venable_d = (state_d == ACK2);
        vdata_d   = venable_d ? {vector_base, sel_d} : '0;
        // Fully nested: only a strictly higher-priority request interrupts service.
        int_d     = (state_d == IDLE) && cand_valid &&
                    ((isr_q == '0) || ((cand - lp_q - 3'd1) < (isr_top - lp_q - 3'd1)));
    end

    assign interrupt               = int_q;
    assign freeze                  = freeze_q;
    assign clear_interrupt_request = clr_q;
    assign in_service_register     = isr_q;
    assign vector_data             = vdata_q;
    assign vector_enable           = venable_q;

endmodule

// File: tb/tb_kf8259_interrupt_sequencer.sv
// Directed bench for kf8259_interrupt_sequencer with hand-computed expectations.
module tb_kf8259_interrupt_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] irr;
    logic [7:0] mask;
    logic       ack;
    logic [4:0] vbase;
    logic       auto_eoi;
    logic       nse;
    logic       se;
    logic [2:0] eoi_lvl;
    logic       rot;
    logic       intr;
    logic       frz;
    logic [7:0] clr;
    logic [7:0] isr;
    logic [7:0] vdata;
    logic       ven;

    int errors = 0;
    int checks = 0;

    kf8259_interrupt_sequencer dut (
        .clock                      (clock),
        .reset                      (reset),
        .interrupt_request_register (irr),
        .interrupt_mask             (mask),
        .interrupt_acknowledge      (ack),
        .vector_base                (vbase),
        .auto_eoi_config            (auto_eoi),
        .non_specific_eoi           (nse),
        .specific_eoi               (se),
        .eoi_level                  (eoi_lvl),
        .rotate_on_eoi              (rot),
        .interrupt                  (intr),
        .freeze                     (frz),
        .clear_interrupt_request    (clr),
        .in_service_register        (isr),
        .vector_data                (vdata),
        .vector_enable              (ven)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full INTA pair; new_irr models the request latch after its clear pulse.
    task automatic ack_cycle(input string tag, input logic [7:0] exp_clr,
                             input logic [7:0] exp_isr1, input logic [7:0] exp_vec,
                             input logic [7:0] exp_isr_end, input logic [7:0] new_irr);
        ack = 1'b1; tick();
        chk({tag, ".a1_freeze"}, 8'(frz), 8'h01);
        chk({tag, ".a1_clr"}, clr, exp_clr);
        chk({tag, ".a1_isr"}, isr, exp_isr1);
        chk({tag, ".a1_int"}, 8'(intr), 8'h00);
        irr = new_irr;
        ack = 1'b0; tick();
        chk({tag, ".w2_freeze"}, 8'(frz), 8'h01);
        chk({tag, ".w2_clr"}, clr, 8'h00);
        chk({tag, ".w2_ven"}, 8'(ven), 8'h00);
        ack = 1'b1; tick();
        chk({tag, ".a2_ven"}, 8'(ven), 8'h01);
        chk({tag, ".a2_vec"}, vdata, exp_vec);
        chk({tag, ".a2_freeze"}, 8'(frz), 8'h01);
        ack = 1'b0; tick();
        chk({tag, ".end_ven"}, 8'(ven), 8'h00);
        chk({tag, ".end_freeze"}, 8'(frz), 8'h00);
        chk({tag, ".end_isr"}, isr, exp_isr_end);
    endtask

    initial begin
        reset = 1'b1; irr = '0; mask = '0; ack = 1'b0; vbase = 5'h01;
        auto_eoi = 1'b0; nse = 1'b0; se = 1'b0; eoi_lvl = '0; rot = 1'b0;
        tick(); tick();
        chk("rst.int", 8'(intr), 8'h00);
        chk("rst.freeze", 8'(frz), 8'h00);
        chk("rst.clr", clr, 8'h00);
        chk("rst.isr", isr, 8'h00);
        chk("rst.vec", vdata, 8'h00);
        chk("rst.ven", 8'(ven), 8'h00);

        // Basic service of IR2 out of {IR2, IR5}
        reset = 1'b0; irr = 8'h24; tick();
        chk("basic.int", 8'(intr), 8'h01);
        ack_cycle("basic", 8'h04, 8'h04, 8'h0A, 8'h04, 8'h00);

        // Fully nested: IR4 blocked by IR2 in service, IR0 interrupts
        irr = 8'h10; tick();
        chk("nest.blocked", 8'(intr), 8'h00);
        irr = 8'h01; tick();
        chk("nest.int", 8'(intr), 8'h01);
        ack_cycle("nest", 8'h01, 8'h05, 8'h08, 8'h05, 8'h00);
        nse = 1'b1; tick(); nse = 1'b0;
        chk("nest.nse1", isr, 8'h04);
        nse = 1'b1; tick(); nse = 1'b0;
        chk("nest.nse2", isr, 8'h00);

        // Spurious acknowledge
        irr = 8'h00; tick();
        chk("spur.int", 8'(intr), 8'h00);
        ack_cycle("spur", 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00);

        // Auto-EOI
        auto_eoi = 1'b1; irr = 8'h08; tick();
        chk("aeoi.int", 8'(intr), 8'h01);
        ack_cycle("aeoi", 8'h08, 8'h08, 8'h0B, 8'h00, 8'h00);
        auto_eoi = 1'b0;

        // Rotation: IR0 becomes lowest priority, IR7 then wins over IR0
        irr = 8'h01; tick();
        ack_cycle("rot_pre", 8'h01, 8'h01, 8'h08, 8'h01, 8'h00);
        se = 1'b1; eoi_lvl = 3'd0; rot = 1'b1; tick();
        se = 1'b0; rot = 1'b0;
        chk("rot.seoi", isr, 8'h00);
        irr = 8'h81; tick();
        chk("rot.int", 8'(intr), 8'h01);
        ack_cycle("rot", 8'h80, 8'h80, 8'h0F, 8'h80, 8'h01);
        se = 1'b1; nse = 1'b1; eoi_lvl = 3'd7; tick();
        se = 1'b0; nse = 1'b0;
        chk("rot.clear", isr, 8'h00);

        // Reset during WAIT2, then a clean cycle
        irr = 8'h02; tick();
        ack = 1'b1; tick();
        chk("rstw.isr_set", isr, 8'h02);
        irr = 8'h00;
        ack = 1'b0; tick();
        chk("rstw.freeze", 8'(frz), 8'h01);
        irr = 8'h02;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rstw.freeze0", 8'(frz), 8'h00);
        chk("rstw.isr0", isr, 8'h00);
        chk("rstw.ven0", 8'(ven), 8'h00);
        tick();
        chk("rstw.int", 8'(intr), 8'h01);
        ack_cycle("rstw", 8'h02, 8'h02, 8'h09, 8'h02, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
